// File: rtl/package_sorter_cfg_if.sv
// Scale-side and host-side signal bundle for package_sorter_cfg.
// master drives weight/config/readback select; slave is the sorter.
interface package_sorter_cfg_if #(
  parameter int WEIGHT_W = 12,
  parameter int NUM_GRP  = 6,
  parameter int CNT_W    = 8
);
  localparam int GRP_W = $clog2(NUM_GRP + 1);
  localparam int AW    = (NUM_GRP > 2) ? $clog2(NUM_GRP - 1) : 1;

  logic [WEIGHT_W-1:0] Weight;
  logic                clear;
  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [WEIGHT_W-1:0] cfg_data;
  logic [GRP_W-1:0]    rd_addr;
  logic [CNT_W-1:0]    rd_count;
  logic [GRP_W-1:0]    CurrentGrp;
  logic                item_valid;
  logic [GRP_W-1:0]    item_grp;
  logic [CNT_W+3:0]    total_count;
  logic [NUM_GRP-1:0]  sat_flags;

  modport master (
    output Weight, clear, cfg_we, cfg_addr, cfg_data, rd_addr,
    input  rd_count, CurrentGrp, item_valid, item_grp,
    input  total_count, sat_flags
  );

  modport slave (
    input  Weight, clear, cfg_we, cfg_addr, cfg_data, rd_addr,
    output rd_count, CurrentGrp, item_valid, item_grp,
    output total_count, sat_flags
  );
endinterface

// File: rtl/package_sorter_cfg.sv
// Package sorter: programmable thresholds, settle filter,
// saturating per-bin and total counters with sticky flags.
module package_sorter_cfg #(
  parameter int WEIGHT_W = 12,
  parameter int NUM_GRP  = 6,
  parameter int CNT_W    = 8,
  parameter int SETTLE   = 2,
  parameter logic [(NUM_GRP-1)*WEIGHT_W-1:0] DEF_THR =
    {12'd2000, 12'd1000, 12'd800, 12'd500, 12'd200}
) (
  input  logic CLK,
  input  logic Reset,
  package_sorter_cfg_if.slave bus
);
  localparam int GRP_W = $clog2(NUM_GRP + 1);
  localparam int NT    = NUM_GRP - 1;
  localparam int TOT_W = CNT_W + 4;
  localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, SETTLING, COUNTED} state_e;

  state_e                       state_q, state_d;
  logic [NT-1:0][WEIGHT_W-1:0]  thr_q, thr_d;
  logic [WEIGHT_W-1:0]          hw_q, hw_d;
  logic [SC_W-1:0]              sc_q, sc_d;
  logic [NUM_GRP-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_GRP-1:0]           sat_q, sat_d;
  logic [TOT_W-1:0]             tot_q, tot_d;
  logic                         iv_q, iv_d;
  logic [GRP_W-1:0]             ig_q, ig_d;
  logic                         do_cnt;
  logic [WEIGHT_W-1:0]          cnt_w;
  logic [GRP_W-1:0]             cnt_grp;
  logic [CNT_W-1:0]             rd_cnt;

  // Lowest matching threshold index wins, so scan downward.
  function automatic logic [GRP_W-1:0] classify(
    input logic [WEIGHT_W-1:0]         w,
    input logic [NT-1:0][WEIGHT_W-1:0] t
  );
    logic [GRP_W-1:0] g;
    g = GRP_W'(NUM_GRP);
    for (int i = NT - 1; i >= 0; i--)
      if (w <= t[i]) g = GRP_W'(i + 1);
    if (w == '0) g = '0;
    return g;
  endfunction

  assign bus.CurrentGrp = classify(bus.Weight, thr_q);
  assign cnt_grp        = classify(cnt_w, thr_q);

  always_comb begin
    thr_d = thr_q;
    if (bus.cfg_we && int'(bus.cfg_addr) < NT)
      thr_d[bus.cfg_addr] = bus.cfg_data;
  end

  always_comb begin
    state_d = state_q;
    hw_d    = hw_q;
    sc_d    = sc_q;
    do_cnt  = 1'b0;
    cnt_w   = hw_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Weight != '0) begin
          hw_d = bus.Weight;
          sc_d = '0;
          if (SETTLE == 0) begin
            do_cnt  = 1'b1;
            cnt_w   = bus.Weight;
            state_d = COUNTED;
          end else begin
            state_d = SETTLING;
          end
        end
      end
      SETTLING: begin
        if (bus.Weight == '0) begin
          state_d = IDLE;
        end else if (bus.Weight != hw_q) begin
          hw_d = bus.Weight;
          sc_d = '0;
        end else if (sc_q == SC_W'(SETTLE - 1)) begin
          do_cnt  = 1'b1;
          state_d = COUNTED;
        end else begin
          sc_d = sc_q + SC_W'(1);
        end
      end
      COUNTED: begin
        if (bus.Weight == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A count that meets clear is still reported on item_valid/item_grp.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    tot_d = tot_q;
    iv_d  = do_cnt;
    ig_d  = do_cnt ? cnt_grp : ig_q;
    if (bus.clear) begin
      cnt_d = '0;
      sat_d = '0;
      tot_d = '0;
    end else if (do_cnt) begin
      for (int i = 0; i < NUM_GRP; i++) begin
        if (cnt_grp == GRP_W'(i + 1) && cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
          if (cnt_d[i] == '1) sat_d[i] = 1'b1;
        end
      end
      if (tot_q != '1) tot_d = tot_q + TOT_W'(1);
    end
  end

  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NUM_GRP; i++)
      if (bus.rd_addr == GRP_W'(i + 1)) rd_cnt = cnt_q[i];
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      thr_q   <= DEF_THR;
      hw_q    <= '0;
      sc_q    <= '0;
      cnt_q   <= '0;
      sat_q   <= '0;
      tot_q   <= '0;
      iv_q    <= 1'b0;
      ig_q    <= '0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      hw_q    <= hw_d;
      sc_q    <= sc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      tot_q   <= tot_d;
      iv_q    <= iv_d;
      ig_q    <= ig_d;
    end
  end

  assign bus.rd_count    = rd_cnt;
  assign bus.item_valid  = iv_q;
  assign bus.item_grp    = ig_q;
  assign bus.total_count = tot_q;
  assign bus.sat_flags   = sat_q;
endmodule

// File: tb/tb_package_sorter_cfg.sv
// Scoreboard bench for package_sorter_cfg: expected bins queued at
// stimulus time, popped on item_valid; counters checked against a model.
module tb_package_sorter_cfg;
  logic CLK = 1'b0;
  logic Reset = 1'b1;

  always #5 CLK = ~CLK;

  package_sorter_cfg_if bus ();

  package_sorter_cfg dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int exp_cnt[1:6];
  int exp_tot;

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_count(int bin);
    if (exp_cnt[bin] < 255) exp_cnt[bin]++;
    if (exp_tot < 4095) exp_tot++;
  endtask

  task automatic model_clear;
    for (int b = 1; b <= 6; b++) exp_cnt[b] = 0;
    exp_tot = 0;
  endtask

  // Settled package: held for exactly the settle window, then removed.
  task automatic pkg(int w, int bin);
    exp_q.push_back(bin);
    model_count(bin);
    bus.Weight = 12'(w);
    repeat (3) tick();
    chk("grp_live", bus.CurrentGrp, bin);
    bus.Weight = '0;
    tick();
    chk("grp_zero", bus.CurrentGrp, 0);
    tick();
  endtask

  task automatic check_counts(string tag);
    for (int b = 1; b <= 6; b++) begin
      bus.rd_addr = 3'(b);
      #1;
      chk($sformatf("%s_cnt%0d", tag, b), bus.rd_count, exp_cnt[b]);
    end
    chk({tag, "_total"}, bus.total_count, exp_tot);
  endtask

  task automatic cfg_write(int addr, int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'(addr);
    bus.cfg_data = 12'(data);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  always @(posedge CLK) begin
    #1;
    if (bus.item_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("item_unexpected", 1, 0);
      else chk("item_grp", bus.item_grp, exp_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ws[6] = '{1, 200, 201, 2000, 2001, 4095};
    int bs[6] = '{1, 1, 2, 5, 6, 6};
    model_clear();
    bus.Weight   = '0;
    bus.clear    = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.rd_addr  = 3'd1;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_total", bus.total_count, 0);
    chk("rst_sat", bus.sat_flags, 0);
    chk("rst_valid", bus.item_valid, 0);
    chk("rst_grp", bus.CurrentGrp, 0);
    chk("rst_rd", bus.rd_count, 0);
    tick();

    // Basic latency: arrival edge k, counted at k+2
    bus.rd_addr = 3'd2;
    exp_q.push_back(2);
    model_count(2);
    bus.Weight = 12'd350;
    tick();
    chk("t1_edge1", bus.rd_count, 0);
    tick();
    chk("t1_edge2", bus.rd_count, 0);
    tick();
    chk("t1_edge3", bus.rd_count, 1);
    chk("t1_total", bus.total_count, 1);
    tick();
    tick();
    bus.Weight = '0;
    tick();
    tick();

    // Threshold boundaries
    for (int i = 0; i < 6; i++) pkg(ws[i], bs[i]);
    check_counts("t2");

    // Bounce then changing weight
    bus.Weight = 12'd700;
    tick();
    bus.Weight = '0;
    tick();
    bus.Weight = 12'd700;
    tick();
    exp_q.push_back(3);
    model_count(3);
    bus.Weight = 12'd710;
    repeat (3) tick();
    bus.Weight = '0;
    tick();
    tick();
    check_counts("t3");

    // Reprogramming and ignored addresses
    cfg_write(0, 50);
    pkg(100, 2);
    cfg_write(7, 1);
    cfg_write(5, 1);
    bus.Weight = 12'd3000;
    #1;
    chk("t4_addr_ign_hi", bus.CurrentGrp, 6);
    bus.Weight = 12'd150;
    #1;
    chk("t4_thr0_new", bus.CurrentGrp, 2);
    bus.Weight = '0;
    check_counts("t4");
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    model_clear();
    bus.Weight = 12'd150;
    #1;
    chk("t4_thr_reload", bus.CurrentGrp, 1);
    bus.Weight = '0;
    check_counts("t4_rst");
    tick();

    // Saturation of bin 1
    for (int n = 0; n < 260; n++) pkg(10, 1);
    check_counts("t5");
    chk("t5_sat", bus.sat_flags, 6'b000001);
    cfg_write(0, 50);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_clear();
    check_counts("t5_clr");
    chk("t5_sat_clr", bus.sat_flags, 0);
    bus.Weight = 12'd100;
    #1;
    chk("t5_thr_kept", bus.CurrentGrp, 2);
    bus.Weight = '0;
    tick();

    // Count edge coinciding with clear
    bus.rd_addr = 3'd2;
    exp_q.push_back(2);
    bus.Weight = 12'd300;
    tick();
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    #1;
    chk("t6_clr_cnt", bus.rd_count, 0);
    chk("t6_clr_total", bus.total_count, 0);
    bus.Weight = '0;
    tick();
    tick();

    // Reset in the middle of settling, weight held across it
    bus.Weight = 12'd300;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    model_clear();
    exp_q.push_back(2);
    model_count(2);
    tick();
    chk("t6_rst_e1", bus.rd_count, 0);
    tick();
    chk("t6_rst_e2", bus.rd_count, 0);
    tick();
    chk("t6_rst_e3", bus.rd_count, 1);
    bus.Weight = '0;
    tick();
    tick();
    check_counts("t6");

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/package_sorter_cfg.md
Name: package_sorter_cfg

Overview:
Parametrised successor of the six-bin package sorter. Classifies a scale weight into NUM_GRP bins using runtime-programmable thresholds. Counts each package once, only after its weight has settled, and uses saturating per-bin counters with sticky saturation flags. Adds a total counter, a soft clear and an indexed count readback, and sits between the scale interface and the display/host register block.

Parameters:
WEIGHT_W, 12, weight input width
NUM_GRP, 6, number of nonzero bins (>=2)
CNT_W, 8, per-bin counter width
SETTLE, 2, extra identical samples required before counting (0 = count on first nonzero sample)
DEF_THR, {12'd2000,12'd1000,12'd800,12'd500,12'd200}, packed reset thresholds, (NUM_GRP-1)*WEIGHT_W bits, entry 0 in LSBs
GRP_W (localparam), clog2(NUM_GRP+1), bin index width

Ports:
CLK  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Weight  in  WEIGHT_W  current scale reading; 0 = empty scale
clear  in  1  sync clear of counters/flags only; thresholds are kept
cfg_we  in  1  threshold write strobe
cfg_addr  in  clog2(NUM_GRP-1)  threshold index
cfg_data  in  WEIGHT_W  threshold value
rd_addr  in  GRP_W  bin select for rd_count (1..NUM_GRP)
rd_count  out  CNT_W  combinational count of bin rd_addr; 0 for rd_addr 0 or >NUM_GRP
CurrentGrp  out  GRP_W  combinational bin of the live Weight
item_valid  out  1  one-cycle pulse in the cycle after a package is counted
item_grp  out  GRP_W  bin of the last counted package
total_count  out  CNT_W+4  saturating count of all packages
sat_flags  out  NUM_GRP  bit i-1 is sticky: bin i counter reached its maximum

Behaviour:
- Classification (combinational): bin 0 if Weight==0. Otherwise the lowest i in 1..NUM_GRP-1 with Weight <= thr[i-1]. Otherwise NUM_GRP. Thresholds that are not ascending are not an error; the lowest index wins.
- Threshold write: on cfg_we, thr[cfg_addr] <= cfg_data. Writes with cfg_addr >= NUM_GRP-1 are ignored. A new value applies to classification from the next cycle.
- Arrival FSM (registers held weight hw and settle counter sc):
  IDLE: if Weight!=0, set hw<=Weight and sc<=0, then go to SETTLING. With SETTLE=0, count immediately and go to COUNTED instead.
  SETTLING: if Weight==0, go to IDLE with no count (bounce). If Weight!=hw, set hw<=Weight and sc<=0. If Weight==hw and sc==SETTLE-1, count hw's bin and go to COUNTED. Otherwise sc<=sc+1.
  COUNTED: wait for Weight==0, then go to IDLE. Weight changes while in COUNTED never produce a second count.
- Count action: the bin is computed from hw with the thresholds in force that cycle. cnt[bin] increments, saturating at 2^CNT_W-1. On reaching the maximum, sat_flags[bin-1] is set. total_count increments, saturating at all-ones. item_valid=1 and item_grp=bin in the next cycle.
- Latency: with SETTLE=S, a stable nonzero weight appearing at edge k is counted at edge k+S. The counter and item_valid are visible after that edge.
- Priority: Reset > clear > count. Reset: all counters, total_count, sat_flags, item_valid and item_grp go to 0; FSM goes to IDLE; thresholds reload DEF_THR. clear: counters, total_count and sat_flags go to 0; FSM and thresholds are unaffected. A count coinciding with clear is discarded, but item_valid/item_grp still report it.
- Reset mid-SETTLING: the package is dropped. If Weight is still nonzero after Reset releases, it is treated as a new arrival.
- A saturated counter holds its value; other bins keep counting.

Test Plan:
1. Defaults, SETTLE=2: Weight 0 -> 350 held 5 cycles -> 0 -> Grp2 count=1 at the 3rd edge after arrival, item_valid one pulse with item_grp=2, total_count=1.
2. Boundaries: weights 1, 200, 201, 2000, 2001, 4095, each separated by 0 -> bins 1, 1, 2, 5, 6, 6 each increment once; CurrentGrp=0 while Weight=0.
3. Bounce: Weight 700 for 1 cycle -> 0, then 700 -> 710 -> 710 -> 710 -> no count from the bounce; exactly one count in bin 3.
4. Reprogram: write thr[0]=50, then weight 100 -> bin 2 counts, not bin 1. cfg_addr=7 write -> ignored. Reset -> thr[0] is 200 again.
5. Saturation: 260 packages into bin 1 (CNT_W=8) -> rd_count(1)=255, sat_flags[0]=1, total_count=260. clear -> all 0 and thresholds unchanged.
6. Simultaneous: count edge coincides with clear -> counters 0, item_valid pulses. Reset during SETTLING with Weight held -> count occurs SETTLE cycles after Reset release.
